pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WR).
- One generic stage register carries an opaque data payload plus a control bundle.
- Adds what the fixed registers lack: valid/ready handshake, stall, flush with bubble insertion, and an optional skid entry that breaks the combinational ready path.
- Instantiated between every pair of pipeline stages in place of the hand-written per-stage registers.

Parameters:
- DATA_W, 128, payload width in bits (busA, busB, results, PC, …), not interpreted.
- CTRL_W, 8, control-bundle width (RegWr, MemtoReg, mulToReg, cp0Op, …); zeroed on flush and bubble.
- SKID, 1, 1 = two-entry (main + skid) buffer with registered in_ready; 0 = single register with combinational ready.

Ports:
- Clk  in  1  pipeline clock, all state on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  kill all held and incoming instructions (branch/exception redirect).
- out_valid  out  1  downstream side holds a valid instruction.
- out_ready  in  1  downstream stage accepts this cycle (0 = stall).
- out_data  out  DATA_W  payload to downstream.
- out_ctrl  out  CTRL_W  control to downstream; all-zero whenever out_valid=0.
- occupancy  out  2  entries held: 0..2 (0..1 when SKID=0).

Behaviour:
- Reset, async on Rst_n=0:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry empty.
  - in_ready=1 when SKID=1.
  - Release is synchronous to Clk.
- Transfers occur on a rising edge: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Order is strictly FIFO, with no duplication or loss unless flush is asserted.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept, main register loads the input. On emit without accept, out_valid goes to 0.
- SKID=1, states EMPTY, ONE (main valid), FULL (main + skid valid):
  - EMPTY: accept -> ONE.
  - ONE, accept & emit: main reloads -> ONE.
  - ONE, accept & ~emit: input goes to skid -> FULL.
  - ONE, emit only -> EMPTY.
  - FULL: in_ready=0. On emit, skid moves to main -> ONE. Otherwise hold.
  - in_ready is registered: in_ready = ~FULL (next state).
- Flush, highest priority:
  - On the edge where flush=1, all entries are invalidated and the state goes to EMPTY.
  - A simultaneous accept is discarded. A simultaneous emit still counts downstream, because downstream sampled out_valid before the edge.
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0, so a bubble never writes the register file, memory, HI/LO or CP0. out_data holds its last value (don't-care).
- Stall: out_ready=0 with the stage in ONE -> out_data/out_ctrl held bit-stable.
- Reset mid-operation: immediate clear, regardless of Clk.
- occupancy equals the state count; it updates on the same edge as the state.

Decomposition:
- Package pipe_pkg:
  - occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - default widths.
  - per-stage control field offsets (CTRL_REGWR, CTRL_MEMTOREG, CTRL_MULTOREG, CTRL_CP0OP_LSB).
- Sub-module pipe_entry:
  - one valid+data+ctrl register with load, clear and async reset.
  - instantiated once (SKID=0) or twice (SKID=1).
  - the parent holds only the state logic.

Test Plan:
- Reset with Rst_n=0 mid-stream, then release -> out_valid=0, out_ctrl=0, occupancy=0 immediately (asynchronous, no edge needed); in_ready=1.
- Stream 0x11..0x18 with in_valid=1, out_ready=1 -> out_data matches 0x11..0x18, each 1 cycle after accept, no gaps; occupancy stays 1.
- SKID=1, out_ready=0 while sending 0xA1, 0xA2, 0xA3 -> 0xA1 in main, 0xA2 in skid, occupancy=2, in_ready=0; 0xA3 held upstream. Release out_ready -> outputs 0xA1, 0xA2, 0xA3 in order.
- FULL state, flush=1 with in_valid=1 (0xB0) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xB0 never appears.
- SKID=0, out_ready toggling 1,0,1,0 with continuous input -> in_ready follows out_ready when full; every item emitted exactly once, in order.
- Stall with ctrl=8'hFF held 5 cycles -> out_ctrl stable at 0xFF with out_valid=1. A flush on the next cycle -> out_ctrl=0x00.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared widths, occupancy encodings and control-field offsets
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_CTRL_W = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Bit positions inside the control bundle, shared by all stages
    localparam int CTRL_REGWR     = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MULTOREG  = 2;
    localparam int CTRL_CP0OP_LSB = 3;

    // State encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// pipe_entry : one valid + data + ctrl holding register (clear beats load)
// Revision   : 1.0
// ============================================================================
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clearing zeroes ctrl so an empty entry never carries live control bits
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : generic pipeline stage register with handshake, flush, skid
// Revision       : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic              accept;
    logic              emit;

    assign accept = in_valid & in_ready;
    assign emit   = main_valid & out_ready;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    generate
        if (SKID != 0) begin : g_skid
            stage_state_t      state;
            stage_state_t      state_nxt;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic              skid_load;
            logic              skid_clear;

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .Clk    (Clk),
                .Rst_n  (Rst_n),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) state <= ST_EMPTY;
                else        state <= state_nxt;
            end

            always_comb begin
                state_nxt   = state;
                main_load   = 1'b0;
                main_clear  = 1'b0;
                skid_load   = 1'b0;
                skid_clear  = 1'b0;
                main_d_data = in_data;
                main_d_ctrl = in_ctrl;
                if (flush) begin
                    state_nxt  = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (accept) begin
                                main_load = 1'b1;
                                state_nxt = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (accept && emit) begin
                                main_load = 1'b1;
                            end else if (accept) begin
                                skid_load = 1'b1;
                                state_nxt = ST_FULL;
                            end else if (emit) begin
                                main_clear = 1'b1;
                                state_nxt  = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (emit) begin
                                main_load   = 1'b1;
                                main_d_data = skid_data;
                                main_d_ctrl = skid_ctrl;
                                skid_clear  = 1'b1;
                                state_nxt   = ST_ONE;
                            end
                        end
                        default: begin
                            state_nxt  = ST_EMPTY;
                            main_clear = 1'b1;
                            skid_clear = 1'b1;
                        end
                    endcase
                end
            end

            // Skid occupancy is a flop, so ready has no path from out_ready
            assign in_ready  = ~skid_valid;
            assign occupancy = state;
        end else begin : g_no_skid
            assign main_d_data = in_data;
            assign main_d_ctrl = in_ctrl;
            assign main_load   = accept & ~flush;
            assign main_clear  = flush | (emit & ~accept);
            assign in_ready    = out_ready | ~main_valid;
            assign occupancy   = main_valid ? OCC_ONE : OCC_EMPTY;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench for SKID=0 (index 0) and SKID=1 (index 1)
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [1:0]    iv;
    logic [1:0]    ordy;
    logic [1:0]    fl;
    logic [1:0]    ir;
    logic [1:0]    ov;
    logic [DW-1:0] idata [2];
    logic [CW-1:0] ictrl [2];
    logic [DW-1:0] od    [2];
    logic [CW-1:0] oc    [2];
    logic [1:0]    occ   [2];

    int    errors = 0;
    int    checks = 0;
    item_t q0[$];
    item_t q1[$];

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idata[0]), .in_ctrl(ictrl[0]), .flush(fl[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_ctrl(oc[0]), .occupancy(occ[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idata[1]), .in_ctrl(ictrl[1]), .flush(fl[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_ctrl(oc[1]), .occupancy(occ[1])
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int k, input item_t x);
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic qpop(input int k, output item_t x);
        x = '0;
        if (k == 0) begin
            if (q0.size() > 0) x = q0.pop_front();
        end else begin
            if (q1.size() > 0) x = q1.pop_front();
        end
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0), flush empties it
    always @(negedge Clk) begin : monitor
        int    n;
        item_t e;
        logic  exp_ir;
        if (Rst_n) begin
            for (int k = 0; k < 2; k++) begin
                n      = qsize(k);
                exp_ir = (k == 1) ? (n < 2) : (ordy[k] | (n == 0));
                chk($sformatf("occupancy[%0d]", k), DW'(occ[k]), DW'(n));
                chk($sformatf("out_valid[%0d]", k), DW'(ov[k]), DW'(n != 0));
                if (!ov[k]) chk($sformatf("bubble_ctrl[%0d]", k), DW'(oc[k]), '0);
                chk($sformatf("in_ready[%0d]", k), DW'(ir[k]), DW'(exp_ir));
                if (n != 0 && ordy[k]) begin
                    qpop(k, e);
                    chk($sformatf("out_data[%0d]", k), od[k], e.d);
                    chk($sformatf("out_ctrl[%0d]", k), DW'(oc[k]), DW'(e.c));
                end
                if (iv[k] && exp_ir && !fl[k]) qpush(k, {idata[k], ictrl[k]});
                if (fl[k]) qclear(k);
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    // Present one item and hold it until the stage takes it
    task automatic send(input int k, input logic [DW-1:0] d, input logic [CW-1:0] c);
        bit done = 1'b0;
        iv[k]    = 1'b1;
        idata[k] = d;
        ictrl[k] = c;
        for (int t = 0; t < 30 && !done; t++) begin
            #1;
            done = ir[k];
            tick;
        end
        chk("send_timeout", DW'(done), DW'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        bit pend [2];
        int j;
        bit acc;
        iv = '0; ordy = 2'b11; fl = '0;
        for (int k = 0; k < 2; k++) begin
            idata[k] = '0;
            ictrl[k] = '0;
            pend[k]  = 1'b0;
        end
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", DW'(ov[k]), '0);
            chk("reset_occupancy", DW'(occ[k]), '0);
            chk("reset_out_ctrl", DW'(oc[k]), '0);
            chk("reset_in_ready", DW'(ir[k]), DW'(1));
        end

        // Back-to-back stream, no gaps expected
        for (int k = 1; k >= 0; k--) begin
            for (int i = 0; i < 8; i++) begin
                send(k, DW'(32'h11 + i), CW'(i));
                chk("stream_valid", DW'(ov[k]), DW'(1));
                chk("stream_occ", DW'(occ[k]), DW'(1));
            end
            iv[k] = 1'b0;
            tick;
        end

        // Skid fill under stall, then release
        ordy[1] = 1'b0;
        send(1, DW'(32'hA1), 8'h01);
        send(1, DW'(32'hA2), 8'h02);
        iv[1] = 1'b1; idata[1] = DW'(32'hA3); ictrl[1] = 8'h03;
        #1;
        chk("skid_in_ready", DW'(ir[1]), '0);
        chk("skid_occ", DW'(occ[1]), DW'(2));
        chk("skid_main", od[1], DW'(32'hA1));
        tick; tick;
        chk("skid_hold_ready", DW'(ir[1]), '0);
        chk("skid_hold_main", od[1], DW'(32'hA1));
        ordy[1] = 1'b1;
        send(1, DW'(32'hA3), 8'h03);
        iv[1] = 1'b0;
        repeat (3) tick;

        // Flush a full stage with a simultaneous incoming item
        ordy[1] = 1'b0;
        send(1, DW'(32'hB1), 8'h11);
        send(1, DW'(32'hB2), 8'h12);
        iv[1] = 1'b1; idata[1] = DW'(32'hB0); ictrl[1] = 8'h5A; fl[1] = 1'b1;
        tick;
        fl[1] = 1'b0; iv[1] = 1'b0;
        chk("flush_valid", DW'(ov[1]), '0);
        chk("flush_ctrl", DW'(oc[1]), '0);
        chk("flush_occ", DW'(occ[1]), '0);
        chk("flush_in_ready", DW'(ir[1]), DW'(1));
        ordy[1] = 1'b1;
        repeat (3) tick;
        chk("flush_no_b0", DW'(ov[1]), '0);

        // Stall with all control bits set, then flush
        ordy[1] = 1'b0;
        send(1, DW'(32'hC5), 8'hFF);
        iv[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", DW'(ov[1]), DW'(1));
            chk("stall_ctrl", DW'(oc[1]), DW'(8'hFF));
            chk("stall_data", od[1], DW'(32'hC5));
            tick;
        end
        fl[1] = 1'b1;
        tick;
        fl[1] = 1'b0; ordy[1] = 1'b1;
        chk("stall_flush_ctrl", DW'(oc[1]), '0);
        chk("stall_flush_valid", DW'(ov[1]), '0);

        // SKID=0 with out_ready toggling under continuous input
        j = 0;
        iv[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ordy[0]  = ~i[0];
            idata[0] = DW'(32'hD0 + j);
            ictrl[0] = CW'(j);
            #1;
            if (ov[0] && !ordy[0]) chk("toggle_in_ready", DW'(ir[0]), '0);
            acc = ir[0];
            tick;
            if (acc) j++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        repeat (2) tick;

        // Asynchronous reset while both stages hold data
        ordy = 2'b00; iv = 2'b11;
        idata[0] = DW'(32'hE0); idata[1] = DW'(32'hE1);
        tick; tick;
        #1 Rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_valid", DW'(ov[k]), '0);
            chk("async_rst_occ", DW'(occ[k]), '0);
            chk("async_rst_ctrl", DW'(oc[k]), '0);
            chk("async_rst_data", od[k], '0);
            qclear(k);
        end
        chk("async_rst_in_ready", DW'(ir[1]), DW'(1));
        iv = 2'b00; ordy = 2'b11;
        tick;
        Rst_n = 1'b1;
        tick;

        // Randomized traffic on both stages
        repeat (600) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    idata[k] = {$urandom, $urandom, $urandom, $urandom};
                    ictrl[k] = CW'($urandom);
                    pend[k]  = 1'b1;
                end
                iv[k]   = pend[k];
                ordy[k] = ($urandom_range(0, 3) != 0);
                fl[k]   = ($urandom_range(0, 19) == 0);
            end
            #1;
            for (int k = 0; k < 2; k++)
                if (iv[k] && ir[k]) pend[k] = 1'b0;
            tick;
        end
        iv = 2'b00; fl = 2'b00; ordy = 2'b11;
        repeat (4) tick;
        chk("drain_q0", DW'(qsize(0)), '0);
        chk("drain_q1", DW'(qsize(1)), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
